crc8_serial_checker: RTL and testbench
======================================

# crc8_serial_checker

Serial frame receiver and CRC-8 checker for the tile's bit-serial datapath. It consumes frames whose payload is followed by a CRC-8 computed with polynomial x^8+x^5+x^4+1 (0x31), initial value 0x00, non-reflected, fed in arrival order, CRC byte MSB first. It reports pass/fail per frame, keeps a good-frame counter, and can show the last payload byte on the output pins.

## Interface
- PAYLOAD_BYTES, 2: payload bytes per frame; total frame length is FRAME_BITS = 8*(PAYLOAD_BYTES+1).
- io_in[0]  in  1  clk; rising-edge clock, the block's only clock.
- io_in[1]  in  1  rst_n; asynchronous, active-low reset.
- io_in[2]  in  1  sdata; serial data bit, sampled on rising clk.
- io_in[3]  in  1  frame_en; high while frame bits are presented.
- io_in[4]  in  1  disp_sel; 0 = status view, 1 = payload view.
- io_in[7:5]  in  3  unused, ignored.
- io_out[7:0]  out  8  display bus:
  - disp_sel=0: [0] done, [1] crc_ok, [2] crc_err, [3] busy, [7:4] good_cnt.
  - disp_sel=1: last latched payload byte.

## Operation
- State machine with states IDLE, SHIFT and WAIT_LOW. Reset enters IDLE.
- IDLE -> SHIFT:
  - Occurs on an edge with frame_en=1.
  - That edge's bit is the first bit of the frame.
  - The CRC register is loaded as if the previous state were 0x00.
  - bit_cnt becomes 1.
- CRC step (register c[7:0]):
  - fb = c[7] ^ sdata.
  - c <= {c[6:0],1'b0} ^ (fb ? 8'h31 : 8'h00).
  - Equivalently: c0=fb, c4=c3^fb, c5=c4^fb, and the other bits shift left.
- SHIFT, frame_en=1:
  - Each edge runs one CRC step and increments bit_cnt.
  - A payload shift register captures the bits.
  - When bit_cnt reaches FRAME_BITS on the sampling edge:
    - Go to WAIT_LOW and pulse done.
    - crc_ok = (next c == 0) and crc_err = !crc_ok.
    - Latch the last payload byte (bits FRAME_BITS-16 .. FRAME_BITS-9, first-arrived bit = MSB).
    - If crc_ok, increment good_cnt.
- SHIFT, frame_en=0 before full length (abort):
  - Go to IDLE and pulse done.
  - crc_ok=0, crc_err=1.
  - good_cnt and the payload latch are unchanged.
- WAIT_LOW:
  - Bits are ignored while frame_en=1.
  - frame_en=0 returns to IDLE.
  - A new frame can start only from IDLE, so at least one low cycle is required between frames.
- crc_ok and crc_err are sticky until the next frame result, and are cleared on entry to SHIFT.
- good_cnt is 4 bits and wraps 15 -> 0.
- busy = (state == SHIFT).

## Timing
- Reset values:
  - state IDLE, c=0x00, bit_cnt=0.
  - done=0, crc_ok=0, crc_err=0, busy=0.
  - good_cnt=0, payload latch 0x00.
  - io_out reads 0x00 in both views.
- Latency:
  - done is high for exactly one cycle, on the cycle after the edge that sampled the last bit (or the abort edge).
  - crc_ok, crc_err, good_cnt and the payload latch update on that same edge.
- busy rises after the first-bit edge and falls with done.
- disp_sel is combinational onto io_out; no register stage.
- Reset asserted mid-frame: all state returns to reset values immediately. No done pulse. Counts are lost.
- A frame_en glitch high for one cycle from IDLE is a 1-bit frame: SHIFT, then abort (crc_err) on the next edge if frame_en is low.

## Structure
- Package crc8_pkg holds:
  - CRC8_POLY = 8'h31 and CRC8_INIT = 8'h00.
  - The state typedef (IDLE, SHIFT, WAIT_LOW).
  - A width constant for good_cnt (4).
- Sub-module crc8_serial_lfsr:
  - Inputs: current c, sdata and load_init.
  - Output: next c.
  - Purely combinational one-step update, reusable by a future transmitter.
- The top level holds the FSM, bit counter (clog2(FRAME_BITS+1) bits), payload shift register, flags, counter and output mux.

## Test plan
- Reset with frame_en=0 -> io_out=0x00 in both views, state IDLE.
- Frame 0x00 0x00 0x00 (24 bits, frame_en high 24 cycles) -> one-cycle done, crc_ok=1, good_cnt=1; disp_sel=1 shows 0x00.
- Frame 0x00 0x01 0x31 -> crc_ok=1, good_cnt increments; disp_sel=1 shows 0x01.
- Frame 0x00 0x01 0x30 -> crc_err=1, good_cnt unchanged, payload view 0x01.
- frame_en dropped after 10 bits -> done pulse, crc_err=1; then a valid 0x00 0x01 0x31 frame passes. Also frame_en held 30 cycles on a valid frame -> result at bit 24, extra bits ignored, single done.
- 17 back-to-back good frames (one idle cycle each) -> good_cnt=1 (wrapped). rst_n pulsed low at bit 12 of the next frame -> immediate all-zero outputs, no done.

Source files
------------

// File: rtl/crc8_pkg.sv
// Shared constants and types for the serial CRC-8 receiver and any future transmitter.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY  = 8'h31;
  localparam logic [7:0] CRC8_INIT  = 8'h00;
  localparam int         GOOD_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

endpackage

// File: rtl/crc8_serial_lfsr.sv
// One-bit CRC-8 update (poly 0x31, MSB-first). Purely combinational so a
// transmitter can reuse it. load_init substitutes the initial value for c,
// which lets the first bit of a frame be folded in on the same edge it arrives.
module crc8_serial_lfsr
  import crc8_pkg::*;
(
  input  logic [7:0] c,
  input  logic       sdata,
  input  logic       load_init,
  output logic [7:0] c_next
);

  logic [7:0] base;
  logic       fb;

  // Single LFSR step: shift left, fold the polynomial in when the feedback bit is set.
  always_comb begin
    base   = load_init ? CRC8_INIT : c;
    fb     = base[7] ^ sdata;
    c_next = {base[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  end

endmodule

// File: rtl/crc8_serial_checker.sv
// Bit-serial frame receiver: accumulates CRC-8 over payload+CRC byte, reports
// pass/fail per frame, counts good frames and exposes the last payload byte.
module crc8_serial_checker
  import crc8_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 2
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int FRAME_BITS = 8 * (PAYLOAD_BYTES + 1);
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  // Holds the most recent 15 bits; on the final edge bits [14:7] are the last payload byte.
  localparam int SHREG_W    = 15;

  logic       clk;
  logic       rst_n;
  logic       sdata;
  logic       frame_en;
  logic       disp_sel;
  logic [2:0] unused_io;

  assign clk       = io_in[0];
  assign rst_n     = io_in[1];
  assign sdata     = io_in[2];
  assign frame_en  = io_in[3];
  assign disp_sel  = io_in[4];
  assign unused_io = io_in[7:5];

  state_t                  state;
  state_t                  next_state;
  logic [7:0]              crc;
  logic [7:0]              crc_next;
  logic [CNT_W-1:0]        bit_cnt;
  logic [SHREG_W-1:0]      shreg;
  logic [7:0]              payload;
  logic [GOOD_CNT_W-1:0]   good_cnt;
  logic                    done;
  logic                    crc_ok;
  logic                    crc_err;
  logic                    busy;

  logic start;
  logic step;
  logic full;
  logic abort;

  crc8_serial_lfsr u_lfsr (
    .c         (crc),
    .sdata     (sdata),
    .load_init (start),
    .c_next    (crc_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and per-edge datapath strobes.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    step       = 1'b0;
    full       = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_en) begin
          next_state = SHIFT;
          start      = 1'b1;
        end
      end
      SHIFT: begin
        if (frame_en) begin
          step = 1'b1;
          if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
            full       = 1'b1;
            next_state = WAIT_LOW;
          end
        end else begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!frame_en) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // CRC register, bit counter and payload shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc     <= CRC8_INIT;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (start) begin
      crc     <= crc_next;
      bit_cnt <= CNT_W'(1);
      shreg   <= {shreg[SHREG_W-2:0], sdata};
    end else if (step) begin
      crc     <= crc_next;
      bit_cnt <= bit_cnt + CNT_W'(1);
      shreg   <= {shreg[SHREG_W-2:0], sdata};
    end
  end

  // Frame result flags, good-frame counter and payload latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
      good_cnt <= '0;
      payload  <= 8'h00;
    end else begin
      done <= full | abort;
      if (start) begin
        crc_ok  <= 1'b0;
        crc_err <= 1'b0;
      end else if (full) begin
        crc_ok  <= (crc_next == 8'h00);
        crc_err <= (crc_next != 8'h00);
        payload <= shreg[14:7];
        if (crc_next == 8'h00) good_cnt <= good_cnt + GOOD_CNT_W'(1);
      end else if (abort) begin
        crc_ok  <= 1'b0;
        crc_err <= 1'b1;
      end
    end
  end

  assign busy = (state == SHIFT);

  // Display mux, combinational on disp_sel.
  always_comb begin
    if (disp_sel) io_out = payload;
    else          io_out = {good_cnt, busy, crc_err, crc_ok, done};
  end

endmodule

// File: tb/tb_crc8_serial_checker.sv
// Directed + randomized bench for crc8_serial_checker with a bytewise CRC reference.
module tb_crc8_serial_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sdata = 1'b0;
  logic       frame_en = 1'b0;
  logic       disp_sel = 1'b0;
  logic [2:0] spare = 3'b000;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int total = 0;
  int bad   = 0;

  // Reference state
  int         exp_good = 0;
  logic [7:0] exp_last = 8'h00;
  logic       exp_ok   = 1'b0;
  logic       exp_err  = 1'b0;

  assign io_in = {spare, disp_sel, frame_en, sdata, rst_n, clk};

  crc8_serial_checker #(.PAYLOAD_BYTES(2)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  // Bytewise CRC-8 (poly 0x31, init 0): XOR byte into register, then 8 shifts.
  function automatic logic [7:0] crc_byte(input logic [7:0] crc_in, input logic [7:0] b);
    logic [7:0] r;
    r = crc_in ^ b;
    for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h31) : (r << 1);
    return r;
  endfunction

  function automatic logic [7:0] crc_frame(input logic [23:0] f);
    return crc_byte(crc_byte(crc_byte(8'h00, f[23:16]), f[15:8]), f[7:0]);
  endfunction

  function automatic logic [23:0] good_frame(input logic [15:0] p);
    return {p, crc_byte(crc_byte(8'h00, p[15:8]), p[7:0])};
  endfunction

  function automatic logic [7:0] status(input logic d, input logic b);
    logic [3:0] g;
    g = exp_good[3:0];
    return {g, b, exp_err, exp_ok, d};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_payload(input string tag);
    disp_sel = 1'b1;
    #1;
    chk(tag, io_out, exp_last);
    disp_sel = 1'b0;
    #1;
  endtask

  // Send a 24-bit frame, holding frame_en for 24+extra cycles, then one low cycle.
  task automatic send_frame(input string tag, input logic [23:0] f, input int extra);
    logic ok;
    ok = (crc_frame(f) == 8'h00);
    frame_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      sdata = f[23-i];
      tick();
      if (i == 0) begin
        exp_ok = 1'b0; exp_err = 1'b0;
        chk({tag, "_first"}, io_out, status(1'b0, 1'b1));
      end
    end
    exp_ok  = ok;
    exp_err = !ok;
    if (ok) exp_good = (exp_good + 1) % 16;
    exp_last = f[15:8];
    chk({tag, "_done"}, io_out, status(1'b1, 1'b0));
    for (int i = 0; i < extra; i++) begin
      sdata = 1'($urandom_range(0, 1));
      tick();
      chk({tag, "_extra"}, io_out, status(1'b0, 1'b0));
    end
    frame_en = 1'b0;
    sdata    = 1'b0;
    tick();
    if (extra == 0) chk({tag, "_after"}, io_out, status(1'b0, 1'b0));
    chk_payload({tag, "_payload"});
  endtask

  // Present n bits then drop frame_en early.
  task automatic send_abort(input string tag, input int n);
    frame_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      sdata = 1'($urandom_range(0, 1));
      tick();
      if (i == 0) begin
        exp_ok = 1'b0; exp_err = 1'b0;
      end
    end
    frame_en = 1'b0;
    tick();
    exp_err = 1'b1;
    chk({tag, "_done"}, io_out, status(1'b1, 1'b0));
    tick();
    chk({tag, "_after"}, io_out, status(1'b0, 1'b0));
    chk_payload({tag, "_payload"});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_en = 1'b0;
    #3;
    exp_good = 0; exp_last = 8'h00; exp_ok = 1'b0; exp_err = 1'b0;
    chk("reset_status", io_out, 8'h00);
    chk_payload("reset_payload");
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [23:0] f;
    logic [15:0] p;

    // Reset state
    #2;
    do_reset();
    chk("idle_status", io_out, 8'h00);

    // Directed frames
    send_frame("zero", 24'h000000, 0);
    send_frame("good01", 24'h000131, 0);
    send_frame("bad01", 24'h000130, 0);

    // Abort after 10 bits, then a valid frame
    send_abort("abort10", 10);
    send_frame("good_after_abort", 24'h000131, 0);

    // frame_en held 30 cycles: result at bit 24 only
    send_frame("long_en", good_frame(16'hA55A), 6);

    // One-cycle frame_en glitch
    send_abort("glitch", 1);

    // Randomized good and corrupted frames
    for (int n = 0; n < 8; n++) begin
      p = 16'($urandom);
      f = good_frame(p);
      if ($urandom_range(0, 1) == 1) f[7:0] = f[7:0] ^ 8'($urandom_range(1, 255));
      send_frame("rand", f, 0);
    end

    // 17 back-to-back good frames from reset: counter wraps to 1
    do_reset();
    for (int n = 0; n < 17; n++) send_frame("b2b", good_frame(16'($urandom)), 0);
    chk("wrap_cnt", {4'h0, io_out[7:4]}, 8'h01);

    // Reset mid-frame at bit 12
    f = good_frame(16'($urandom));
    frame_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sdata = f[23-i];
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_status", io_out, 8'h00);
    disp_sel = 1'b1;
    #1;
    chk("midrst_payload", io_out, 8'h00);
    disp_sel = 1'b0;
    tick();
    chk("midrst_nodone", io_out, 8'h00);
    frame_en = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("midrst_release", io_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
